// File: rtl/cordic_prenorm.sv
// Left-shift pre-normaliser for the CORDIC sqrt path: shifts a positive operand left by 2 bits per cycle into [2^17, 2^19).
// Optional 4-bit fast step when CORDIC_PRENORM_FAST_EN is defined (results unchanged, latency shorter).
module cordic_prenorm #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero,
  output logic             err
);

  typedef enum logic {S_IDLE, S_CHK} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_shift_cnt;
  logic             r_done;
  logic             r_zero;
  logic             r_err;

  logic w_accept;
  logic w_neg;
  logic w_is_zero;
  logic w_norm;
  logic w_fin;

  // A start seen during the done cycle is dropped; the next edge may accept it.
  assign w_accept  = (r_state == S_IDLE) && start && !r_done;
  assign w_neg     = r_reg[WIDTH-1];
  assign w_is_zero = (r_reg == '0);
  assign w_norm    = r_reg[WIDTH-2] | r_reg[WIDTH-3];
  assign w_fin     = w_neg | w_is_zero | w_norm;

`ifdef CORDIC_PRENORM_FAST_EN
  logic w_fast;
  // Four leading magnitude bits clear means two 2-bit steps could not finish: take them at once.
  assign w_fast = (r_reg[WIDTH-2:WIDTH-5] == '0) && !w_is_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CHK;
      S_CHK:   if (w_fin)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CHK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg       <= '0;
      r_cnt       <= '0;
      r_dout      <= '0;
      r_shift_cnt <= '0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_reg  <= din;
        r_cnt  <= '0;
        r_zero <= 1'b0;
        r_err  <= 1'b0;
      end else if (r_state == S_CHK) begin
        if (w_neg) begin
          r_err       <= 1'b1;
          r_dout      <= r_reg;
          r_shift_cnt <= '0;
          r_done      <= 1'b1;
        end else if (w_is_zero) begin
          r_zero      <= 1'b1;
          r_dout      <= '0;
          r_shift_cnt <= '0;
          r_done      <= 1'b1;
        end else if (w_norm) begin
          r_dout      <= r_reg;
          r_shift_cnt <= r_cnt;
          r_done      <= 1'b1;
`ifdef CORDIC_PRENORM_FAST_EN
        end else if (w_fast) begin
          r_reg <= r_reg << 4;
          r_cnt <= r_cnt + CNT_W'(4);
`endif
        end else begin
          r_reg <= r_reg << 2;
          r_cnt <= r_cnt + CNT_W'(2);
        end
      end
    end
  end

  assign done      = r_done;
  assign dout      = r_dout;
  assign shift_cnt = r_shift_cnt;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule
